// File: rtl/vga_scanout.sv
// vga_scanout: reader side of the 1-bpp video memory.
// Produces VGA timing, fetches one bit per pixel tick and drives the display pins
// one pixel tick after the counters, plus vblank / frame_start for the rasterizer.
module vga_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] mem_x,
    output logic [10:0] mem_y,
    output logic        mem_rd,
    input  logic        mem_data,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        video_on,
    output logic        vblank,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] L_H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] L_V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] L_HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] L_HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] L_VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] L_VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] L_H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] L_V_LAST  = 11'(V_TOTAL - 1);

    logic [10:0] r_h_cnt_p0;
    logic [10:0] r_v_cnt_p0;

    logic        r_hsync_p1;
    logic        r_vsync_p1;
    logic [11:0] r_rgb_p1;
    logic        r_video_on_p1;
    logic        r_vblank_p1;
    logic        r_frame_start_p1;

    logic        w_active_p0;
    logic        w_hsync_n_p0;
    logic        w_vsync_n_p0;
    logic [11:0] w_pix_p0;
    logic        w_at_origin_p0;

    // Stage 0: pixel / line counters, advanced once per pixel tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt_p0 <= '0;
            r_v_cnt_p0 <= '0;
        end else if (pix_en) begin
            if (r_h_cnt_p0 == L_H_LAST) begin
                r_h_cnt_p0 <= '0;
                r_v_cnt_p0 <= (r_v_cnt_p0 == L_V_LAST) ? 11'd0 : r_v_cnt_p0 + 11'd1;
            end else begin
                r_h_cnt_p0 <= r_h_cnt_p0 + 11'd1;
            end
        end
    end

    // Addresses are forced to 0 in blanking so the memory never sees out-of-range x/y;
    // the colour mux ignores mem_data outside the active area so X there cannot leak.
    assign w_active_p0    = (r_h_cnt_p0 < L_H_ACT) && (r_v_cnt_p0 < L_V_ACT);
    assign w_hsync_n_p0   = !((r_h_cnt_p0 >= L_HS_BEG) && (r_h_cnt_p0 < L_HS_END));
    assign w_vsync_n_p0   = !((r_v_cnt_p0 >= L_VS_BEG) && (r_v_cnt_p0 < L_VS_END));
    assign w_pix_p0       = w_active_p0 ? (mem_data ? FG_COLOR : BG_COLOR) : 12'h000;
    assign w_at_origin_p0 = (r_h_cnt_p0 == 11'd0) && (r_v_cnt_p0 == 11'd0);

    assign mem_rd = w_active_p0;
    assign mem_x  = w_active_p0 ? r_h_cnt_p0 : 11'd0;
    assign mem_y  = w_active_p0 ? r_v_cnt_p0 : 11'd0;

    // Stage 1: register pin outputs on the pixel tick, one tick behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync_p1    <= 1'b1;
            r_vsync_p1    <= 1'b1;
            r_rgb_p1      <= 12'h000;
            r_video_on_p1 <= 1'b0;
            r_vblank_p1   <= 1'b0;
        end else if (pix_en) begin
            r_hsync_p1    <= w_hsync_n_p0;
            r_vsync_p1    <= w_vsync_n_p0;
            r_rgb_p1      <= w_pix_p0;
            r_video_on_p1 <= w_active_p0;
            r_vblank_p1   <= (r_v_cnt_p0 >= L_V_ACT);
        end
    end

    // frame_start is re-evaluated every clk so it lasts one clk even when pix_en is sparse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_start_p1 <= 1'b0;
        end else begin
            r_frame_start_p1 <= pix_en && w_at_origin_p0;
        end
    end

    assign hsync       = r_hsync_p1;
    assign vsync       = r_vsync_p1;
    assign rgb         = r_rgb_p1;
    assign video_on    = r_video_on_p1;
    assign vblank      = r_vblank_p1;
    assign frame_start = r_frame_start_p1;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench. A reduced-timing instance (35x33 frame) exercises
// frame-level behaviour; a default-timing instance exercises 640x480 line timing.
module tb_vga_scanout;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    always #5 clk = ~clk;

    // small instance: H 20/4/6/5 (total 35), V 24/3/2/4 (total 33), frame 1155 ticks
    logic [10:0] s_mem_x, s_mem_y;
    logic        s_mem_rd, s_mem_data, s_hsync, s_vsync, s_video_on, s_vblank, s_frame_start;
    logic [11:0] s_rgb;

    // full instance: default 640x480 timing
    logic [10:0] f_mem_x, f_mem_y;
    logic        f_mem_rd, f_mem_data, f_hsync, f_vsync, f_video_on, f_vblank, f_frame_start;
    logic [11:0] f_rgb;

    // memory models: small has a single lit pixel at (10,20); full is all ones.
    // Outside the active area both return X.
    assign s_mem_data = s_mem_rd ? ((s_mem_x == 11'd10) && (s_mem_y == 11'd20)) : 1'bx;
    assign f_mem_data = f_mem_rd ? 1'b1 : 1'bx;

    vga_scanout #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(24), .V_FP(3), .V_SYNC(2), .V_BP(4),
        .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .mem_x(s_mem_x), .mem_y(s_mem_y), .mem_rd(s_mem_rd), .mem_data(s_mem_data),
        .hsync(s_hsync), .vsync(s_vsync), .rgb(s_rgb), .video_on(s_video_on),
        .vblank(s_vblank), .frame_start(s_frame_start)
    );

    vga_scanout u_full (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .mem_x(f_mem_x), .mem_y(f_mem_y), .mem_rd(f_mem_rd), .mem_data(f_mem_data),
        .hsync(f_hsync), .vsync(f_vsync), .rgb(f_rgb), .video_on(f_video_on),
        .vblank(f_vblank), .frame_start(f_frame_start)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // measurement state
    int f_fff_cnt, f_hs_low, f_first_off, f_rgb_x, n_fall;
    int f_fall [2];
    logic prev_f_hs, prev_s_vs;
    int s_fff_cnt, s_vs_low, s_vblank_cnt, s_von_cnt, s_rd_cnt, s_addr_bad, s_vs_fall, n_fs;
    int fs_t [4];
    int hold_bad, fs_idle_bad, n_fs_d;
    int fs_c [4];
    logic [63:0] snap, now_v;

    initial begin
        // ---------------- reset with pix_en held high ----------------
        rst    = 1'b1;
        pix_en = 1'b1;
        tick(); tick(); tick();
        check("rst_hsync",  {31'd0, s_hsync}, 32'd1);
        check("rst_vsync",  {31'd0, s_vsync}, 32'd1);
        check("rst_rgb",    {20'd0, s_rgb}, 32'h000);
        check("rst_von",    {31'd0, s_video_on}, 32'd0);
        check("rst_vblank", {31'd0, s_vblank}, 32'd0);
        check("rst_fs",     {31'd0, s_frame_start}, 32'd0);
        check("rst_mem_x",  {21'd0, s_mem_x}, 32'd0);
        check("rst_mem_y",  {21'd0, s_mem_y}, 32'd0);
        check("rst_f_hsync", {31'd0, f_hsync}, 32'd1);
        check("rst_f_fs",   {31'd0, f_frame_start}, 32'd0);
        rst = 1'b0;

        // ---------------- continuous pix_en: line and frame timing ----------------
        f_fff_cnt = 0; f_hs_low = 0; f_first_off = 0; f_rgb_x = 0; n_fall = 0;
        f_fall[0] = 0; f_fall[1] = 0;
        s_fff_cnt = 0; s_vs_low = 0; s_vblank_cnt = 0; s_von_cnt = 0; s_rd_cnt = 0;
        s_addr_bad = 0; s_vs_fall = 0; n_fs = 0;
        for (int i = 0; i < 4; i++) fs_t[i] = 0;
        prev_f_hs = f_hsync;
        prev_s_vs = s_vsync;
        for (int t = 1; t <= 2400; t++) begin
            tick();
            if (t == 1) begin
                check("first_fs",    {31'd0, s_frame_start}, 32'd1);
                check("first_von",   {31'd0, s_video_on}, 32'd1);
                check("first_rgb_s", {20'd0, s_rgb}, 32'h000);
                check("first_rgb_f", {20'd0, f_rgb}, 32'hFFF);
                check("first_fs_f",  {31'd0, f_frame_start}, 32'd1);
            end
            if (t == 2) check("fs_one_clk", {31'd0, s_frame_start}, 32'd0);
            if (t == 710) begin
                check("lit_mem_x",  {21'd0, s_mem_x}, 32'd10);
                check("lit_mem_y",  {21'd0, s_mem_y}, 32'd20);
                check("lit_mem_rd", {31'd0, s_mem_rd}, 32'd1);
            end
            if (t == 711) check("lit_rgb", {20'd0, s_rgb}, 32'hFFF);

            if (t <= 800) begin
                if (f_rgb === 12'hFFF) f_fff_cnt++;
                if (f_hsync === 1'b0) f_hs_low++;
            end
            if (f_first_off == 0 && f_rgb !== 12'hFFF) f_first_off = t;
            if (prev_f_hs === 1'b1 && f_hsync === 1'b0 && n_fall < 2) begin
                f_fall[n_fall] = t;
                n_fall++;
            end
            prev_f_hs = f_hsync;
            if ($isunknown(f_rgb)) f_rgb_x++;

            if (t <= 1155) begin
                if (s_rgb === 12'hFFF) s_fff_cnt++;
                if (s_vsync === 1'b0) s_vs_low++;
                if (s_vblank === 1'b1) s_vblank_cnt++;
                if (s_video_on === 1'b1) s_von_cnt++;
                if (s_mem_rd === 1'b1) s_rd_cnt++;
                if (s_mem_rd === 1'b0 && (s_mem_x != 11'd0 || s_mem_y != 11'd0)) s_addr_bad++;
                if (s_mem_x >= 11'd20 || s_mem_y >= 11'd24) s_addr_bad++;
            end
            if (prev_s_vs === 1'b1 && s_vsync === 1'b0 && s_vs_fall == 0) s_vs_fall = t;
            prev_s_vs = s_vsync;
            if (s_frame_start === 1'b1) begin
                if (n_fs < 4) fs_t[n_fs] = t;
                n_fs++;
            end
        end
        check("f_fff_run_end",  f_first_off, 641);
        check("f_fff_count",    f_fff_cnt, 640);
        check("f_hs_low_count", f_hs_low, 96);
        check("f_hs_fall0",     f_fall[0], 657);
        check("f_hs_fall1",     f_fall[1], 1457);
        check("f_rgb_no_x",     f_rgb_x, 0);
        check("s_fff_count",    s_fff_cnt, 1);
        check("s_vs_low_count", s_vs_low, 70);
        check("s_vs_fall",      s_vs_fall, 946);
        check("s_vblank_count", s_vblank_cnt, 315);
        check("s_von_count",    s_von_cnt, 480);
        check("s_rd_count",     s_rd_cnt, 480);
        check("s_addr_range",   s_addr_bad, 0);
        check("s_fs_count",     n_fs, 3);
        check("s_fs_t0",        fs_t[0], 1);
        check("s_fs_t1",        fs_t[1], 1156);
        check("s_fs_t2",        fs_t[2], 2311);

        // ---------------- reset mid-frame inside h/v sync (h=25, v=27) ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 970; t++) tick();
        check("pre_hsync",  {31'd0, s_hsync}, 32'd0);
        check("pre_vsync",  {31'd0, s_vsync}, 32'd0);
        check("pre_vblank", {31'd0, s_vblank}, 32'd1);
        check("pre_mem_rd", {31'd0, s_mem_rd}, 32'd0);
        rst = 1'b1;
        tick();
        check("mid_rst_mem_x",  {21'd0, s_mem_x}, 32'd0);
        check("mid_rst_mem_y",  {21'd0, s_mem_y}, 32'd0);
        check("mid_rst_mem_rd", {31'd0, s_mem_rd}, 32'd1);
        check("mid_rst_hsync",  {31'd0, s_hsync}, 32'd1);
        check("mid_rst_vsync",  {31'd0, s_vsync}, 32'd1);
        check("mid_rst_vblank", {31'd0, s_vblank}, 32'd0);
        check("mid_rst_rgb",    {20'd0, s_rgb}, 32'h000);
        check("mid_rst_von",    {31'd0, s_video_on}, 32'd0);
        check("mid_rst_fs",     {31'd0, s_frame_start}, 32'd0);
        rst = 1'b0;
        tick();
        check("restart_fs",    {31'd0, s_frame_start}, 32'd1);
        check("restart_von",   {31'd0, s_video_on}, 32'd1);
        check("restart_mem_x", {21'd0, s_mem_x}, 32'd1);
        tick();
        check("restart_fs_end", {31'd0, s_frame_start}, 32'd0);
        check("restart_mem_x2", {21'd0, s_mem_x}, 32'd2);

        // ---------------- pix_en every second clk ----------------
        rst = 1'b1;
        pix_en = 1'b1;
        tick();
        rst = 1'b0;
        hold_bad = 0; fs_idle_bad = 0; n_fs_d = 0;
        for (int i = 0; i < 4; i++) fs_c[i] = 0;
        snap = {s_mem_x, s_mem_y, s_mem_rd, s_hsync, s_vsync, s_rgb, s_video_on, s_vblank,
                f_hsync, f_vsync, f_rgb, f_video_on, 1'b0};
        for (int c = 1; c <= 4700; c++) begin
            pix_en = (c % 2 == 1);
            tick();
            now_v = {s_mem_x, s_mem_y, s_mem_rd, s_hsync, s_vsync, s_rgb, s_video_on, s_vblank,
                     f_hsync, f_vsync, f_rgb, f_video_on, 1'b0};
            if (!pix_en) begin
                if (now_v !== snap) hold_bad++;
                if (s_frame_start !== 1'b0) fs_idle_bad++;
            end
            if (s_frame_start === 1'b1) begin
                if (n_fs_d < 4) fs_c[n_fs_d] = c;
                n_fs_d++;
            end
            snap = now_v;
        end
        check("half_hold",     hold_bad, 0);
        check("half_fs_idle",  fs_idle_bad, 0);
        check("half_fs_count", n_fs_d, 3);
        check("half_fs_c0",    fs_c[0], 1);
        check("half_fs_c1",    fs_c[1], 2311);
        check("half_fs_c2",    fs_c[2], 4621);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
